// File: rtl/xif_core_offloader.sv
// Core-side CORE-V-XIF initiator: issues decoded instructions to a coprocessor,
// commits or kills each one, and turns matching results into register write-backs.
//
// state    | meaning
// S_IDLE   | waiting for an upstream instruction (gated by ID reuse and outstanding cap)
// S_ISSUE  | issue request held stable until the coprocessor is ready
// S_COMMIT | single-cycle commit/kill strobe for the issued ID
module xif_core_offloader #(
    parameter int X_ID_WIDTH      = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int XLEN            = 32
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   instr_valid_i,
    output logic                                   instr_ready_o,
    input  logic [31:0]                            instr_i,
    input  logic [XLEN-1:0]                        rs1_i,
    input  logic [XLEN-1:0]                        rs2_i,
    input  logic                                   flush_i,
    output logic                                   issue_valid_o,
    input  logic                                   issue_ready_i,
    output logic [31:0]                            issue_instr_o,
    output logic [X_ID_WIDTH-1:0]                  issue_id_o,
    output logic [XLEN-1:0]                        issue_rs0_o,
    output logic [XLEN-1:0]                        issue_rs1_o,
    output logic [1:0]                             issue_rs_valid_o,
    input  logic                                   issue_accept_i,
    input  logic                                   issue_writeback_i,
    output logic                                   commit_valid_o,
    output logic [X_ID_WIDTH-1:0]                  commit_id_o,
    output logic                                   commit_kill_o,
    input  logic                                   result_valid_i,
    output logic                                   result_ready_o,
    input  logic [X_ID_WIDTH-1:0]                  result_id_i,
    input  logic [4:0]                             result_rd_i,
    input  logic [XLEN-1:0]                        result_data_i,
    input  logic                                   result_we_i,
    output logic                                   wb_valid_o,
    output logic [4:0]                             wb_rd_o,
    output logic [XLEN-1:0]                        wb_data_o,
    output logic                                   rejected_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   error_o
);

    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int NID = 2 ** X_ID_WIDTH;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t                  state;
    logic [X_ID_WIDTH-1:0]   next_id;
    logic [X_ID_WIDTH-1:0]   id_q;
    logic [NID-1:0]          pending;
    logic [NID-1:0]          pending_nxt;
    logic [CW-1:0]           outstanding;
    logic                    accept_q;
    logic                    writeback_q;
    logic [31:0]             instr_q;
    logic [XLEN-1:0]         rs0_q;
    logic [XLEN-1:0]         rs1_q;

    logic in_commit;
    logic set_pend;
    logic res_hit;
    logic res_miss;

    assign in_commit = (state == S_COMMIT);
    // Flush is sampled combinationally in the commit cycle itself.
    assign set_pend  = in_commit && accept_q && writeback_q && !flush_i;
    // A result for the ID being committed this cycle sees the old bitmap, so it misses.
    assign res_hit   = result_valid_i && pending[result_id_i];
    assign res_miss  = result_valid_i && !pending[result_id_i];

    always_comb begin
        pending_nxt = pending;
        if (res_hit) begin
            pending_nxt[result_id_i] = 1'b0;
        end
        if (set_pend) begin
            pending_nxt[id_q] = 1'b1;
        end
    end

    assign instr_ready_o    = rst_ni && (state == S_IDLE) && (outstanding < MAX_CNT)
                              && !pending[next_id];
    assign issue_valid_o    = (state == S_ISSUE);
    assign issue_instr_o    = instr_q;
    assign issue_id_o       = id_q;
    assign issue_rs0_o      = rs0_q;
    assign issue_rs1_o      = rs1_q;
    assign issue_rs_valid_o = {2{issue_valid_o}};
    assign commit_valid_o   = in_commit;
    assign commit_id_o      = id_q;
    assign commit_kill_o    = in_commit && (!accept_q || flush_i);
    assign rejected_o       = in_commit && !accept_q;
    assign result_ready_o   = rst_ni;
    assign outstanding_o    = outstanding;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= S_IDLE;
            next_id     <= '0;
            id_q        <= '0;
            pending     <= '0;
            outstanding <= '0;
            accept_q    <= 1'b0;
            writeback_q <= 1'b0;
            instr_q     <= '0;
            rs0_q       <= '0;
            rs1_q       <= '0;
            wb_valid_o  <= 1'b0;
            wb_rd_o     <= '0;
            wb_data_o   <= '0;
            error_o     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (instr_valid_i && instr_ready_o) begin
                        instr_q <= instr_i;
                        rs0_q   <= rs1_i;
                        rs1_q   <= rs2_i;
                        id_q    <= next_id;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (issue_ready_i) begin
                        next_id     <= next_id + X_ID_WIDTH'(1);
                        accept_q    <= issue_accept_i;
                        writeback_q <= issue_writeback_i;
                        state       <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            pending <= pending_nxt;
            if (set_pend && !res_hit) begin
                outstanding <= outstanding + CW'(1);
            end else if (res_hit && !set_pend) begin
                outstanding <= outstanding - CW'(1);
            end

            wb_valid_o <= res_hit && result_we_i;
            if (res_hit) begin
                wb_rd_o   <= result_rd_i;
                wb_data_o <= result_data_i;
            end
            if (res_miss) begin
                error_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_xif_core_offloader.sv
// Scoreboard bench for xif_core_offloader: commit and write-back expectations are
// queued when stimulus is driven and checked by a monitor when the DUT emits them.
module tb_xif_core_offloader;

    localparam int W    = 4;
    localparam int MAXO = 4;
    localparam int XLEN = 32;
    localparam int CW   = $clog2(MAXO + 1);

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            instr_valid_i;
    logic            instr_ready_o;
    logic [31:0]     instr_i;
    logic [XLEN-1:0] rs1_i, rs2_i;
    logic            flush_i;
    logic            issue_valid_o;
    logic            issue_ready_i;
    logic [31:0]     issue_instr_o;
    logic [W-1:0]    issue_id_o;
    logic [XLEN-1:0] issue_rs0_o, issue_rs1_o;
    logic [1:0]      issue_rs_valid_o;
    logic            issue_accept_i, issue_writeback_i;
    logic            commit_valid_o;
    logic [W-1:0]    commit_id_o;
    logic            commit_kill_o;
    logic            result_valid_i, result_ready_o;
    logic [W-1:0]    result_id_i;
    logic [4:0]      result_rd_i;
    logic [XLEN-1:0] result_data_i;
    logic            result_we_i;
    logic            wb_valid_o;
    logic [4:0]      wb_rd_o;
    logic [XLEN-1:0] wb_data_o;
    logic            rejected_o;
    logic [CW-1:0]   outstanding_o;
    logic            error_o;

    xif_core_offloader #(.X_ID_WIDTH(W), .MAX_OUTSTANDING(MAXO), .XLEN(XLEN)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o), .instr_i(instr_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .flush_i(flush_i),
        .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
        .issue_instr_o(issue_instr_o), .issue_id_o(issue_id_o),
        .issue_rs0_o(issue_rs0_o), .issue_rs1_o(issue_rs1_o),
        .issue_rs_valid_o(issue_rs_valid_o),
        .issue_accept_i(issue_accept_i), .issue_writeback_i(issue_writeback_i),
        .commit_valid_o(commit_valid_o), .commit_id_o(commit_id_o), .commit_kill_o(commit_kill_o),
        .result_valid_i(result_valid_i), .result_ready_o(result_ready_o),
        .result_id_i(result_id_i), .result_rd_i(result_rd_i),
        .result_data_i(result_data_i), .result_we_i(result_we_i),
        .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
        .rejected_o(rejected_o), .outstanding_o(outstanding_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [W-1:0] id;
        logic         kill;
        logic         rej;
    } commit_t;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_t;

    commit_t commit_q[$];
    wb_t     wb_q[$];

    int          n_pass  = 0;
    int          n_total = 0;
    logic [15:0] model_pend;
    int          model_out;
    logic        model_err;
    logic        mon_en = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    always @(negedge clk_i) begin
        commit_t c;
        wb_t     w;
        if (mon_en) begin
            if (commit_valid_o) begin
                if (commit_q.size() == 0) begin
                    check("commit_unexpected", 1, 0);
                end else begin
                    c = commit_q.pop_front();
                    check("commit_id", commit_id_o, c.id);
                    check("commit_kill", commit_kill_o, c.kill);
                    check("rejected", rejected_o, c.rej);
                end
            end else begin
                check("rejected_idle", rejected_o, 0);
            end
            if (wb_valid_o) begin
                if (wb_q.size() == 0) begin
                    check("wb_unexpected", 1, 0);
                end else begin
                    w = wb_q.pop_front();
                    check("wb_rd", wb_rd_o, w.rd);
                    check("wb_data", wb_data_o, w.data);
                end
            end
        end
    end

    task automatic clear_model();
        model_pend = '0;
        model_out  = 0;
        model_err  = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_instr_ready", instr_ready_o, 0);
        check("rst_result_ready", result_ready_o, 0);
        check("rst_issue_valid", issue_valid_o, 0);
        check("rst_outstanding", outstanding_o, 0);
        check("rst_error", error_o, 0);
        check("rst_wb_valid", wb_valid_o, 0);
        check("rst_commit_valid", commit_valid_o, 0);
        rst_ni = 1'b1;
        clear_model();
        @(posedge clk_i);
        #1;
    endtask

    task automatic offload(input logic [31:0] ins, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic acc, input logic wbk, input logic fl,
                           input int delay, input logic [W-1:0] exp_id);
        int guard = 0;
        while (!instr_ready_o && guard < 100) begin
            @(posedge clk_i);
            #1;
            guard++;
        end
        check("instr_ready_wait", instr_ready_o, 1);
        instr_valid_i = 1'b1;
        instr_i = ins;
        rs1_i = a;
        rs2_i = b;
        @(posedge clk_i);
        #1;
        instr_valid_i = 1'b0;
        instr_i = '0;
        rs1_i = '0;
        rs2_i = '0;
        check("issue_valid", issue_valid_o, 1);
        check("issue_id", issue_id_o, exp_id);
        check("issue_instr", issue_instr_o, ins);
        check("issue_rs0", issue_rs0_o, a);
        check("issue_rs1", issue_rs1_o, b);
        check("issue_rs_valid", issue_rs_valid_o, 2'b11);
        for (int i = 0; i < delay; i++) begin
            @(posedge clk_i);
            #1;
            check("bp_valid", issue_valid_o, 1);
            check("bp_instr", issue_instr_o, ins);
            check("bp_id", issue_id_o, exp_id);
            check("bp_rs0", issue_rs0_o, a);
            check("bp_rs1", issue_rs1_o, b);
            check("bp_no_commit", commit_valid_o, 0);
        end
        issue_ready_i = 1'b1;
        issue_accept_i = acc;
        issue_writeback_i = wbk;
        commit_q.push_back('{id: exp_id, kill: (!acc || fl), rej: !acc});
        @(posedge clk_i);
        #1;
        issue_ready_i = 1'b0;
        issue_accept_i = 1'b0;
        issue_writeback_i = 1'b0;
        flush_i = fl;
        check("commit_latency", commit_valid_o, 1);
        check("issue_dropped", issue_valid_o, 0);
        if (acc && wbk && !fl) begin
            model_pend[exp_id] = 1'b1;
            model_out++;
        end
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        check("outstanding_commit", outstanding_o, model_out);
    endtask

    task automatic send_result(input logic [W-1:0] id, input logic [4:0] rd,
                               input logic [XLEN-1:0] data, input logic we);
        check("result_ready", result_ready_o, 1);
        result_valid_i = 1'b1;
        result_id_i = id;
        result_rd_i = rd;
        result_data_i = data;
        result_we_i = we;
        if (model_pend[id]) begin
            model_pend[id] = 1'b0;
            model_out--;
            if (we) wb_q.push_back('{rd: rd, data: data});
        end else begin
            model_err = 1'b1;
        end
        @(posedge clk_i);
        #1;
        result_valid_i = 1'b0;
        result_we_i = 1'b0;
        check("error", error_o, model_err);
        check("outstanding_result", outstanding_o, model_out);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst_ni = 1'b0;
        instr_valid_i = 1'b0;
        instr_i = '0;
        rs1_i = '0;
        rs2_i = '0;
        flush_i = 1'b0;
        issue_ready_i = 1'b0;
        issue_accept_i = 1'b0;
        issue_writeback_i = 1'b0;
        result_valid_i = 1'b0;
        result_id_i = '0;
        result_rd_i = '0;
        result_data_i = '0;
        result_we_i = 1'b0;
        clear_model();
        repeat (2) @(posedge clk_i);
        #1;
        mon_en = 1'b1;
        do_reset();
        check("post_rst_instr_ready", instr_ready_o, 1);
        check("post_rst_result_ready", result_ready_o, 1);

        // single offload with write-back
        offload(32'h0000_500B, 32'd5, 32'd7, 1'b1, 1'b1, 1'b0, 0, 4'd0);
        send_result(4'd0, 5'd10, 32'd12, 1'b1);

        // backpressure, reject, then a flushed write-back transaction
        offload(32'h1234_567B, 32'hAAAA_0001, 32'h5555_0002, 1'b1, 1'b0, 1'b0, 5, 4'd1);
        offload(32'h0000_702B, 32'd1, 32'd2, 1'b0, 1'b1, 1'b0, 0, 4'd2);
        offload(32'h0000_712B, 32'd3, 32'd4, 1'b1, 1'b0, 1'b0, 0, 4'd3);
        offload(32'h0000_722B, 32'd8, 32'd9, 1'b1, 1'b1, 1'b1, 0, 4'd4);
        send_result(4'd4, 5'd3, 32'd99, 1'b1);

        // saturation and out-of-order return
        do_reset();
        for (int i = 0; i < 4; i++)
            offload(32'h0000_800B + 32'(i), 32'(i), 32'(i * 3), 1'b1, 1'b1, 1'b0, 0, W'(i));
        check("sat_outstanding", outstanding_o, 4);
        check("sat_instr_ready", instr_ready_o, 0);
        send_result(4'd2, 5'd22, 32'd102, 1'b1);
        check("unsat_instr_ready", instr_ready_o, 1);
        send_result(4'd0, 5'd20, 32'd100, 1'b1);
        send_result(4'd3, 5'd23, 32'd103, 1'b1);
        send_result(4'd1, 5'd21, 32'd101, 1'b1);
        check("ooo_outstanding", outstanding_o, 0);
        check("ooo_error", error_o, 0);

        // ID wrap, then reset while in ISSUE
        do_reset();
        for (int i = 0; i < 17; i++)
            offload(32'h0000_900B + 32'(i), 32'(i), 32'(i + 1), 1'b1, 1'b0, 1'b0, 0, W'(i));
        instr_valid_i = 1'b1;
        instr_i = 32'hDEAD_000B;
        @(posedge clk_i);
        #1;
        instr_valid_i = 1'b0;
        check("pre_rst_issue_valid", issue_valid_o, 1);
        check("pre_rst_issue_id", issue_id_o, 1);
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        check("mid_rst_issue_valid", issue_valid_o, 0);
        check("mid_rst_outstanding", outstanding_o, 0);
        check("mid_rst_commit", commit_valid_o, 0);
        rst_ni = 1'b1;
        clear_model();
        repeat (3) @(posedge clk_i);
        #1;
        check("post_mid_rst_commit", commit_valid_o, 0);
        check("post_mid_rst_ready", instr_ready_o, 1);

        check("commit_q_empty", commit_q.size(), 0);
        check("wb_q_empty", wb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
